control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
- Multi-cycle control sequencer directly upstream of the instruction-fetch (PC) stage.
- Latches the opcode of the instruction addressed by PC, walks FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, and drives datapath enables.
- Produces the fetch stage's control inputs, Init/Halt/Beq/PC_CTRL, so PC advances exactly once per instruction, in its final cycle.

Parameters:
- INSTR_W, 16, instruction width; opcode is Instr[INSTR_W-1:INSTR_W-4].
- ALUOP_W, 3, width of ALUOp.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Instr  input  INSTR_W  instruction-memory read data at current PC.
- Init  output  1  fetch-stage PC clear.
- Halt  output  1  fetch-stage PC hold.
- Beq  output  1  relative-branch qualify; fetch stage ANDs it with ALUZero.
- PC_CTRL  output  1  1 = PC loads absolute target.
- IRWrite  output  1  instruction register load.
- ALUOp  output  ALUOP_W  0 ADD, 1 SUB, 2 AND, 3 OR.
- ALUSrcImm  output  1  ALU B operand is the immediate.
- RegWrite  output  1  register-file write enable.
- MemRead  output  1  data-memory read.
- MemWrite  output  1  data-memory write.
- MemToReg  output  1  writeback source is memory.
- State  output  3  current state encoding, for debug.
- IllegalOp  output  1  sticky illegal-opcode flag.

Behaviour:
- Reset: single clock CLK; Reset is asynchronous active-high.
  - While Reset is high: State=INIT, latched opcode=0, IllegalOp=0.
  - Outputs are Moore-decoded from the state, so during reset Init=1 and every other output is 0.
- States: INIT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6.
- Output decode: Moore from State plus latched opcode (op).
  - Halt=1 in every state except INIT and the last state of the current instruction.
  - Init=1 only in INIT.
- INIT: Init=1, Halt=0; next state FETCH.
- FETCH: IRWrite=1; op <= Instr opcode at the edge; next state DECODE.
- Opcode map and state sequences (last state has Halt=0):
  - 0 ADD, 1 SUB, 2 AND, 3 OR: FETCH, DECODE, EXEC, WB. ALUOp per op. RegWrite=1 in WB.
  - 8 ADDI: as ADD, with ALUSrcImm=1 in EXEC and WB.
  - 4 LW: FETCH, DECODE, EXEC(ADD, Imm), MEM(MemRead=1), WB(MemToReg=1, RegWrite=1). 5 cycles.
  - 5 SW: FETCH, DECODE, EXEC(ADD, Imm), MEM(MemWrite=1). 4 cycles.
  - 6 BEQ: FETCH, DECODE, EXEC(ALUOp=SUB, Beq=1). 3 cycles. The ALUZero used by the fetch stage is valid in EXEC.
  - 7 JMP: FETCH, DECODE(PC_CTRL=1). 2 cycles.
  - F HALT: FETCH, DECODE, then HALTED. Halt=1 in DECODE and HALTED; all enables 0. HALTED holds until Reset.
  - Other opcodes (9-E): see Optional Feature.
- Control timing:
  - Beq and PC_CTRL are asserted only in their instruction's last state; 0 elsewhere.
  - RegWrite and MemWrite are never asserted in FETCH or DECODE.
- Reset mid-instruction: immediate return to INIT; enables drop asynchronously. No partial writes after the Reset edge.
- Throughput: CPI = 2 (JMP), 3 (BEQ), 4 (R-type, ADDI, SW), 5 (LW).

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: opcodes 9-E go FETCH, DECODE, HALTED. IllegalOp=1 from entering HALTED until Reset. Halt=1 throughout.
- Undefined: opcodes 9-E execute as a NOP: FETCH, DECODE with Halt=0 in DECODE, no enables. IllegalOp is tied 0.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (OP_ADD..OP_HALT);
  - state encodings (ST_INIT..ST_HALTED);
  - ALUOp codes.
- Sub-module op_decode: combinational; maps opcode to the flags is_rtype, is_imm, is_load, is_store, is_branch, is_jump, is_halt, is_illegal. The FSM consumes these flags.

Test Plan:
- Reset, then release; Instr=0x0123 (ADD) → Init=1 for 1 cycle; then State 1,2,3,5. Halt=0 only in WB; RegWrite=1 only in WB; ALUOp=0.
- Instr=0x4xxx (LW) → 5-cycle sequence; MemRead=1 in MEM; MemToReg=RegWrite=1 in WB; Halt=0 only in WB.
- Instr=0x6xxx (BEQ) → EXEC has Beq=1, ALUOp=1, Halt=0; returns to FETCH next cycle. Instr=0x7xxx (JMP) → DECODE has PC_CTRL=1, Halt=0.
- Instr=0xFxxx → DECODE then HALTED; Halt=1 for 20+ cycles with all enables 0. Reset pulse → INIT with Init=1.
- Reset asserted asynchronously during LW MEM → same-edge State=0, MemRead=0; no RegWrite afterwards.
- Instr=0xA000:
  - with CTRL_ILLEGAL_TRAP_EN → HALTED, IllegalOp=1 (sticky);
  - without it → 2-cycle NOP, IllegalOp=0, next FETCH.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, state and ALU encodings for the multi-cycle control sequencer.
package cpu_ctrl_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_LW   = 4'h4;
   localparam logic [3:0] OP_SW   = 4'h5;
   localparam logic [3:0] OP_BEQ  = 4'h6;
   localparam logic [3:0] OP_JMP  = 4'h7;
   localparam logic [3:0] OP_ADDI = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALTED = 3'd6
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;

   // R-type opcodes 0..3 are laid out to match the ALU codes directly.
   function automatic logic [2:0] rtype_alu(input logic [3:0] op);
      return {1'b0, op[1:0]};
   endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier; every opcode maps to exactly one flag.
module op_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [3:0] op,
   output logic       is_rtype,
   output logic       is_imm,
   output logic       is_load,
   output logic       is_store,
   output logic       is_branch,
   output logic       is_jump,
   output logic       is_halt,
   output logic       is_illegal
);

   always_comb begin
      is_rtype   = 1'b0;
      is_imm     = 1'b0;
      is_load    = 1'b0;
      is_store   = 1'b0;
      is_branch  = 1'b0;
      is_jump    = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: is_rtype  = 1'b1;
         OP_ADDI:                       is_imm    = 1'b1;
         OP_LW:                         is_load   = 1'b1;
         OP_SW:                         is_store  = 1'b1;
         OP_BEQ:                        is_branch = 1'b1;
         OP_JMP:                        is_jump   = 1'b1;
         OP_HALT:                       is_halt   = 1'b1;
         default:                       is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control sequencer feeding the PC fetch stage; outputs are registered Moore decodes.
// Build option CTRL_ILLEGAL_TRAP_EN: opcodes 9-E trap into HALTED and set IllegalOp, else they run as a NOP.
module control_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int INSTR_W = 16,
   parameter int ALUOP_W = 3
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [INSTR_W-1:0] Instr,
   output logic               Init,
   output logic               Halt,
   output logic               Beq,
   output logic               PC_CTRL,
   output logic               IRWrite,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               ALUSrcImm,
   output logic               RegWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               MemToReg,
   output logic [2:0]         State,
   output logic               IllegalOp
);

`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   state_t     state, nxt_state;
   logic [3:0] op, nxt_op;
   logic       is_rtype, is_imm, is_load, is_store;
   logic       is_branch, is_jump, is_halt, is_illegal;

   logic       n_init, n_halt, n_beq, n_pc_ctrl, n_ir_write, n_imm;
   logic       n_reg_write, n_mem_read, n_mem_write, n_mem_to_reg;
   logic [2:0] n_alu;

   // Opcode is captured on the edge leaving FETCH; decode it one cycle early so
   // outputs can be registered against the state being entered.
   assign nxt_op = (state == ST_FETCH) ? Instr[INSTR_W-1 -: 4] : op;

   op_decode u_op_decode (
      .op         (nxt_op),
      .is_rtype   (is_rtype),
      .is_imm     (is_imm),
      .is_load    (is_load),
      .is_store   (is_store),
      .is_branch  (is_branch),
      .is_jump    (is_jump),
      .is_halt    (is_halt),
      .is_illegal (is_illegal)
   );

   always_comb begin
      nxt_state = state;
      case (state)
         ST_INIT:   nxt_state = ST_FETCH;
         ST_FETCH:  nxt_state = ST_DECODE;
         ST_DECODE: begin
            if (is_jump || (is_illegal && !TRAP_EN))
               nxt_state = ST_FETCH;
            else if (is_halt || is_illegal)
               nxt_state = ST_HALTED;
            else
               nxt_state = ST_EXEC;
         end
         ST_EXEC: begin
            if (is_branch)
               nxt_state = ST_FETCH;
            else if (is_load || is_store)
               nxt_state = ST_MEM;
            else
               nxt_state = ST_WB;
         end
         ST_MEM:    nxt_state = is_store ? ST_FETCH : ST_WB;
         ST_WB:     nxt_state = ST_FETCH;
         ST_HALTED: nxt_state = ST_HALTED;
         default:   nxt_state = ST_INIT;
      endcase
   end

   // Halt is low only in the final state of an instruction, which is where PC advances.
   always_comb begin
      n_init       = 1'b0;
      n_halt       = 1'b0;
      n_beq        = 1'b0;
      n_pc_ctrl    = 1'b0;
      n_ir_write   = 1'b0;
      n_imm        = 1'b0;
      n_reg_write  = 1'b0;
      n_mem_read   = 1'b0;
      n_mem_write  = 1'b0;
      n_mem_to_reg = 1'b0;
      n_alu        = ALU_ADD;
      case (nxt_state)
         ST_INIT:  n_init = 1'b1;
         ST_FETCH: begin
            n_halt     = 1'b1;
            n_ir_write = 1'b1;
         end
         ST_DECODE: begin
            n_halt    = !(is_jump || (is_illegal && !TRAP_EN));
            n_pc_ctrl = is_jump;
         end
         ST_EXEC: begin
            n_halt = !is_branch;
            n_beq  = is_branch;
            n_imm  = is_imm || is_load || is_store;
            if (is_rtype)
               n_alu = rtype_alu(nxt_op);
            else if (is_branch)
               n_alu = ALU_SUB;
         end
         ST_MEM: begin
            n_halt      = !is_store;
            n_mem_read  = is_load;
            n_mem_write = is_store;
         end
         ST_WB: begin
            n_reg_write  = 1'b1;
            n_mem_to_reg = is_load;
            n_imm        = is_imm;
            if (is_rtype)
               n_alu = rtype_alu(nxt_op);
         end
         ST_HALTED: n_halt = 1'b1;
         default:   n_init = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state     <= ST_INIT;
         op        <= 4'h0;
         IllegalOp <= 1'b0;
         Init      <= 1'b1;
         Halt      <= 1'b0;
         Beq       <= 1'b0;
         PC_CTRL   <= 1'b0;
         IRWrite   <= 1'b0;
         ALUOp     <= '0;
         ALUSrcImm <= 1'b0;
         RegWrite  <= 1'b0;
         MemRead   <= 1'b0;
         MemWrite  <= 1'b0;
         MemToReg  <= 1'b0;
      end else begin
         state     <= nxt_state;
         op        <= nxt_op;
         IllegalOp <= IllegalOp || (TRAP_EN && is_illegal && nxt_state == ST_HALTED);
         Init      <= n_init;
         Halt      <= n_halt;
         Beq       <= n_beq;
         PC_CTRL   <= n_pc_ctrl;
         IRWrite   <= n_ir_write;
         ALUOp     <= ALUOP_W'(n_alu);
         ALUSrcImm <= n_imm;
         RegWrite  <= n_reg_write;
         MemRead   <= n_mem_read;
         MemWrite  <= n_mem_write;
         MemToReg  <= n_mem_to_reg;
      end
   end

   assign State = state;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm; control outputs are grouped into one vector for compact checks.
module tb_control_fsm;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [15:0] Instr;
   logic        Init, Halt, Beq, PC_CTRL, IRWrite, ALUSrcImm;
   logic        RegWrite, MemRead, MemWrite, MemToReg, IllegalOp;
   logic [2:0]  ALUOp;
   logic [2:0]  State;
   logic [9:0]  ctl;

   int n_cmp = 0;
   int n_bad = 0;

   // Bit order: Init Halt Beq PC_CTRL IRWrite ALUSrcImm RegWrite MemRead MemWrite MemToReg
   localparam logic [9:0] C_INIT  = 10'b1000000000;
   localparam logic [9:0] C_FETCH = 10'b0100100000;
   localparam logic [9:0] C_BUSY  = 10'b0100000000;
   localparam logic [9:0] C_RWB   = 10'b0000001000;
   localparam logic [9:0] C_IEXE  = 10'b0100010000;
   localparam logic [9:0] C_IWB   = 10'b0000011000;
   localparam logic [9:0] C_LMEM  = 10'b0100000100;
   localparam logic [9:0] C_LWB   = 10'b0000001001;
   localparam logic [9:0] C_SMEM  = 10'b0000000010;
   localparam logic [9:0] C_BEQ   = 10'b0010000000;
   localparam logic [9:0] C_JMP   = 10'b0001000000;
   localparam logic [9:0] C_NONE  = 10'b0000000000;

   assign ctl = {Init, Halt, Beq, PC_CTRL, IRWrite, ALUSrcImm, RegWrite, MemRead, MemWrite, MemToReg};

   control_fsm #(.INSTR_W(16), .ALUOP_W(3)) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .Instr     (Instr),
      .Init      (Init),
      .Halt      (Halt),
      .Beq       (Beq),
      .PC_CTRL   (PC_CTRL),
      .IRWrite   (IRWrite),
      .ALUOp     (ALUOp),
      .ALUSrcImm (ALUSrcImm),
      .RegWrite  (RegWrite),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .MemToReg  (MemToReg),
      .State     (State),
      .IllegalOp (IllegalOp)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic look(input string tag, input logic [2:0] st, input logic [9:0] c, input logic [2:0] a);
      chk({tag, ".state"}, 32'(State), 32'(st));
      chk({tag, ".ctl"},   32'(ctl),   32'(c));
      chk({tag, ".aluop"}, 32'(ALUOp), 32'(a));
   endtask

   task automatic step(input string tag, input logic [2:0] st, input logic [9:0] c, input logic [2:0] a);
      @(posedge CLK);
      #1;
      look(tag, st, c, a);
   endtask

   task automatic reset_pulse(input string tag);
      @(negedge CLK);
      Reset = 1'b1;
      #2;
      look({tag, ".rst"}, 3'd0, C_INIT, 3'd0);
      chk({tag, ".ill_rst"}, 32'(IllegalOp), 32'd0);
      @(negedge CLK);
      Reset = 1'b0;
      step({tag, ".fetch"}, 3'd1, C_FETCH, 3'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1;
      Instr = 16'h0123;
      #13;
      look("reset", 3'd0, C_INIT, 3'd0);
      chk("reset.ill", 32'(IllegalOp), 32'd0);
      @(negedge CLK);
      Reset = 1'b0;
      #1;
      look("init_hold", 3'd0, C_INIT, 3'd0);
      step("add.fetch", 3'd1, C_FETCH, 3'd0);
      step("add.dec",   3'd2, C_BUSY,  3'd0);
      step("add.exe",   3'd3, C_BUSY,  3'd0);
      step("add.wb",    3'd5, C_RWB,   3'd0);
      step("sub.fetch", 3'd1, C_FETCH, 3'd0);

      Instr = 16'h1456;
      step("sub.dec",   3'd2, C_BUSY,  3'd0);
      step("sub.exe",   3'd3, C_BUSY,  3'd1);
      step("sub.wb",    3'd5, C_RWB,   3'd1);
      step("and.fetch", 3'd1, C_FETCH, 3'd0);

      Instr = 16'h2000;
      step("and.dec",   3'd2, C_BUSY,  3'd0);
      step("and.exe",   3'd3, C_BUSY,  3'd2);
      step("and.wb",    3'd5, C_RWB,   3'd2);
      step("or.fetch",  3'd1, C_FETCH, 3'd0);

      Instr = 16'h3fff;
      step("or.dec",    3'd2, C_BUSY,  3'd0);
      step("or.exe",    3'd3, C_BUSY,  3'd3);
      step("or.wb",     3'd5, C_RWB,   3'd3);
      step("addi.fetch",3'd1, C_FETCH, 3'd0);

      Instr = 16'h8abc;
      step("addi.dec",  3'd2, C_BUSY,  3'd0);
      step("addi.exe",  3'd3, C_IEXE,  3'd0);
      step("addi.wb",   3'd5, C_IWB,   3'd0);
      step("lw.fetch",  3'd1, C_FETCH, 3'd0);

      Instr = 16'h4567;
      step("lw.dec",    3'd2, C_BUSY,  3'd0);
      step("lw.exe",    3'd3, C_IEXE,  3'd0);
      step("lw.mem",    3'd4, C_LMEM,  3'd0);
      step("lw.wb",     3'd5, C_LWB,   3'd0);
      step("sw.fetch",  3'd1, C_FETCH, 3'd0);

      Instr = 16'h5123;
      step("sw.dec",    3'd2, C_BUSY,  3'd0);
      step("sw.exe",    3'd3, C_IEXE,  3'd0);
      step("sw.mem",    3'd4, C_SMEM,  3'd0);
      step("beq.fetch", 3'd1, C_FETCH, 3'd0);

      Instr = 16'h6042;
      step("beq.dec",   3'd2, C_BUSY,  3'd0);
      step("beq.exe",   3'd3, C_BEQ,   3'd1);
      step("jmp.fetch", 3'd1, C_FETCH, 3'd0);

      Instr = 16'h7100;
      step("jmp.dec",   3'd2, C_JMP,   3'd0);
      step("ill.fetch", 3'd1, C_FETCH, 3'd0);

      Instr = 16'hA000;
`ifdef CTRL_ILLEGAL_TRAP_EN
      step("ill.dec",   3'd2, C_BUSY,  3'd0);
      chk("ill.flag_dec", 32'(IllegalOp), 32'd0);
      step("ill.halted",3'd6, C_BUSY,  3'd0);
      chk("ill.flag", 32'(IllegalOp), 32'd1);
      Instr = 16'h0123;
      for (int i = 0; i < 4; i++) begin
         step("ill.sticky", 3'd6, C_BUSY, 3'd0);
         chk("ill.flag_sticky", 32'(IllegalOp), 32'd1);
      end
      reset_pulse("ill");
`else
      step("nop.dec",   3'd2, C_NONE,  3'd0);
      chk("nop.flag", 32'(IllegalOp), 32'd0);
      step("nop.next",  3'd1, C_FETCH, 3'd0);
      chk("nop.flag_next", 32'(IllegalOp), 32'd0);
`endif

      // Reset lands mid-cycle while LW sits in MEM.
      Instr = 16'h4abc;
      step("lwr.dec",   3'd2, C_BUSY,  3'd0);
      step("lwr.exe",   3'd3, C_IEXE,  3'd0);
      step("lwr.mem",   3'd4, C_LMEM,  3'd0);
      #2;
      Reset = 1'b1;
      #1;
      look("lwr.async", 3'd0, C_INIT, 3'd0);
      @(posedge CLK);
      #1;
      look("lwr.held", 3'd0, C_INIT, 3'd0);
      @(negedge CLK);
      Reset = 1'b0;
      step("lwr.fetch", 3'd1, C_FETCH, 3'd0);

      Instr = 16'hF000;
      step("hlt.dec",   3'd2, C_BUSY,  3'd0);
      step("hlt.enter", 3'd6, C_BUSY,  3'd0);
      chk("hlt.ill", 32'(IllegalOp), 32'd0);
      Instr = 16'h0123;
      for (int i = 0; i < 22; i++)
         step("hlt.hold", 3'd6, C_BUSY, 3'd0);
      reset_pulse("hlt");
      step("post.dec",  3'd2, C_BUSY,  3'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
